// File: rtl/fp_round_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_arbiter
// Purpose  : Shares one floating_point_rounder among NUM_REQ FP execution
//            units. Requesters are served round-robin over valid/ready
//            handshakes. The rounding mode of each operation is resolved
//            against the global dynamic mode. The rounded result is held in a
//            single output register that feeds the exponent-adjust/pack stage.
// Ports    : clk, rst           clock, synchronous active-high reset
//            frm                global dynamic rounding mode
//            req_valid/ready    per-requester handshake
//            req_mantissa/grs/  per-requester payload, packed by slice
//            sign/rm/tag
//            out_valid/ready    result handshake
//            out_mantissa       24-bit rounded mantissa (bit 23 = carry)
//            out_inexact        guard|round|sticky of the accepted operation
//            out_invalid_rm     effective rounding mode was illegal
//            out_id, out_tag    granted requester index and its tag
// Revision : 1.0 - initial release
// ============================================================================
module fp_round_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 frm,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*23-1:0]      req_mantissa,
    input  logic [NUM_REQ*3-1:0]       req_grs,
    input  logic [NUM_REQ-1:0]         req_sign,
    input  logic [NUM_REQ*3-1:0]       req_rm,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [23:0]                out_mantissa,
    output logic                       out_inexact,
    output logic                       out_invalid_rm,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int         c_ID_W   = $clog2(NUM_REQ);
    localparam logic [2:0] c_RM_DYN = 3'b111;

    logic [c_ID_W-1:0] r_ptr;
    logic              r_out_valid;
    logic [23:0]       r_out_mantissa;
    logic              r_out_inexact;
    logic              r_out_invalid_rm;
    logic [c_ID_W-1:0] r_out_id;
    logic [TAG_W-1:0]  r_out_tag;

    logic               w_found;
    logic [c_ID_W-1:0]  w_gnt_id;
    logic [NUM_REQ-1:0] w_grant;
    logic [22:0]        w_mant;
    logic [2:0]         w_grs;
    logic               w_sign;
    logic [2:0]         w_rm;
    logic [TAG_W-1:0]   w_tag;
    logic [2:0]         w_eff_rm;
    logic [23:0]        w_rnd_result;
    logic               w_rnd_inexact;
    logic               w_rnd_invalid;
    logic               w_accept;
    logic               w_xfer;

    // Round-robin scan starting at r_ptr+1. The first loop picks the lowest
    // valid index at or below the pointer (the wrapped part of the scan).
    // The second loop overrides it with the lowest valid index above the
    // pointer, which comes first in scan order.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (c_ID_W'(i) <= r_ptr)) begin
                w_found  = 1'b1;
                w_gnt_id = c_ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (c_ID_W'(i) > r_ptr)) begin
                w_found  = 1'b1;
                w_gnt_id = c_ID_W'(i);
            end
        end
    end

    // One-hot grant and payload mux for the granted requester.
    always_comb begin
        w_grant = '0;
        w_mant  = '0;
        w_grs   = '0;
        w_sign  = 1'b0;
        w_rm    = '0;
        w_tag   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_found && (w_gnt_id == c_ID_W'(i))) begin
                w_grant[i] = 1'b1;
                w_mant     = req_mantissa[23*i +: 23];
                w_grs      = req_grs[3*i +: 3];
                w_sign     = req_sign[i];
                w_rm       = req_rm[3*i +: 3];
                w_tag      = req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    assign w_eff_rm = (w_rm == c_RM_DYN) ? frm : w_rm;

    floating_point_rounder u_rounder (
        .i_mantissa   (w_mant),
        .i_grs        (w_grs),
        .i_sign       (w_sign),
        .i_rm         (w_eff_rm),
        .o_result     (w_rnd_result),
        .o_inexact    (w_rnd_inexact),
        .o_invalid_rm (w_rnd_invalid)
    );

    // The output stage can take a new result when it is empty or draining.
    assign w_accept  = ~r_out_valid | out_ready;
    assign w_xfer    = w_found & w_accept & ~rst;
    assign req_ready = w_grant & {NUM_REQ{w_accept & ~rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr            <= c_ID_W'(NUM_REQ - 1);
            r_out_valid      <= 1'b0;
            r_out_mantissa   <= '0;
            r_out_inexact    <= 1'b0;
            r_out_invalid_rm <= 1'b0;
            r_out_id         <= '0;
            r_out_tag        <= '0;
        end else if (w_xfer) begin
            r_ptr            <= w_gnt_id;
            r_out_valid      <= 1'b1;
            r_out_mantissa   <= w_rnd_result;
            r_out_inexact    <= w_rnd_inexact;
            r_out_invalid_rm <= w_rnd_invalid;
            r_out_id         <= w_gnt_id;
            r_out_tag        <= w_tag;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_mantissa   = r_out_mantissa;
    assign out_inexact    = r_out_inexact;
    assign out_invalid_rm = r_out_invalid_rm;
    assign out_id         = r_out_id;
    assign out_tag        = r_out_tag;

endmodule

// ============================================================================
// Module   : floating_point_rounder
// Purpose  : Rounds a normalized 23-bit mantissa using guard/round/sticky
//            bits. The result is 24 bits wide, so a round-up of all-ones
//            shows up as a carry in bit 23. Illegal modes truncate.
// Ports    : i_mantissa, i_grs, i_sign, i_rm -> o_result, o_inexact,
//            o_invalid_rm
// Revision : 1.0 - initial release
// ============================================================================
module floating_point_rounder (
    input  logic [22:0] i_mantissa,
    input  logic [2:0]  i_grs,
    input  logic        i_sign,
    input  logic [2:0]  i_rm,
    output logic [23:0] o_result,
    output logic        o_inexact,
    output logic        o_invalid_rm
);

    localparam logic [2:0] c_RNE = 3'b000;
    localparam logic [2:0] c_RTZ = 3'b001;
    localparam logic [2:0] c_RDN = 3'b010;
    localparam logic [2:0] c_RUP = 3'b011;
    localparam logic [2:0] c_RMM = 3'b100;

    logic w_guard;
    logic w_any;
    logic w_up;

    assign w_guard   = i_grs[2];
    assign w_any     = |i_grs;
    assign o_inexact = w_any;

    always_comb begin
        w_up         = 1'b0;
        o_invalid_rm = 1'b0;
        case (i_rm)
            // Ties go to the even value, so the mantissa LSB breaks the tie.
            c_RNE: w_up = w_guard & (i_grs[1] | i_grs[0] | i_mantissa[0]);
            c_RTZ: w_up = 1'b0;
            c_RDN: w_up = i_sign & w_any;
            c_RUP: w_up = ~i_sign & w_any;
            c_RMM: w_up = w_guard;
            default: begin
                w_up         = 1'b0;
                o_invalid_rm = 1'b1;
            end
        endcase
    end

    assign o_result = {1'b0, i_mantissa} + {23'd0, w_up};

endmodule
`default_nettype wire
